// File: rtl/dual_lane_dispatcher.sv
// Splits one valid/ready byte stream into two buffered lanes: bytes above the
// threshold go to lane A, the rest to lane B. Each lane has a FIFO and a counter.

module dld_lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop_ready,
  output logic                     valid,
  output logic [DATA_W-1:0]        data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop;

  assign valid = (level_q != '0);
  assign data  = valid ? mem_q[rd_ptr_q] : '0;
  assign level = level_q;
  assign count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // The full guard is redundant with the top's in_ready but keeps the lane safe standalone.
    do_push  = push && (level_q != LW'(DEPTH));
    do_pop   = valid && pop_ready;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      count_d         = count_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
    end
  end
endmodule

module dual_lane_dispatcher #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      threshold,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [DATA_W-1:0]      a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [DATA_W-1:0]      b_data,
  output logic [$clog2(DEPTH):0] a_level,
  output logic [$clog2(DEPTH):0] b_level,
  output logic [CNT_W-1:0]       a_count,
  output logic [CNT_W-1:0]       b_count
);
  localparam int NUM_LANES = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  // Lane 0 is A, lane 1 is B.
  logic [NUM_LANES-1:0]             lane_push, lane_ready, lane_valid;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0][LW-1:0]     lane_level;
  logic [NUM_LANES-1:0][CNT_W-1:0]  lane_count;
  logic                             accept, to_a;

  // Any full lane stalls the input, even for bytes bound for the other lane.
  assign in_ready   = (lane_level[0] != LW'(DEPTH)) && (lane_level[1] != LW'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign to_a       = (in_data > threshold);
  assign lane_push  = {accept && !to_a, accept && to_a};
  assign lane_ready = {b_ready, a_ready};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dld_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lane_push[g]),
      .push_data (in_data),
      .pop_ready (lane_ready[g]),
      .valid     (lane_valid[g]),
      .data      (lane_data[g]),
      .level     (lane_level[g]),
      .count     (lane_count[g])
    );
  end

  assign a_valid = lane_valid[0];
  assign b_valid = lane_valid[1];
  assign a_data  = lane_data[0];
  assign b_data  = lane_data[1];
  assign a_level = lane_level[0];
  assign b_level = lane_level[1];
  assign a_count = lane_count[0];
  assign b_count = lane_count[1];
endmodule

// File: tb/tb_dual_lane_dispatcher.sv
// Randomized and directed bench for dual_lane_dispatcher against a queue-based
// reference model; built with a 4-bit counter so wrap-around is exercised.

module tb_dual_lane_dispatcher;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] threshold = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              a_valid, b_valid;
  logic              a_ready = 1'b0, b_ready = 1'b0;
  logic [DATA_W-1:0] a_data, b_data;
  logic [LW-1:0]     a_level, b_level;
  logic [CNT_W-1:0]  a_count, b_count;

  dual_lane_dispatcher #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_level(a_level), .b_level(b_level), .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane plus dispatch totals.
  logic [DATA_W-1:0] qa[$], qb[$];
  int unsigned       ca, cb;
  int                n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [DATA_W-1:0] ha, hb;
    ha = (qa.size() != 0) ? qa[0] : '0;
    hb = (qb.size() != 0) ? qb[0] : '0;
    chk("in_ready", 32'(in_ready), 32'((qa.size() < DEPTH) && (qb.size() < DEPTH)));
    chk("a_valid",  32'(a_valid),  32'(qa.size() != 0));
    chk("b_valid",  32'(b_valid),  32'(qb.size() != 0));
    chk("a_data",   32'(a_data),   32'(ha));
    chk("b_data",   32'(b_data),   32'(hb));
    chk("a_level",  32'(a_level),  32'(qa.size()));
    chk("b_level",  32'(b_level),  32'(qb.size()));
    chk("a_count",  32'(a_count),  ca % (1 << CNT_W));
    chk("b_count",  32'(b_count),  cb % (1 << CNT_W));
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); ca = 0; cb = 0;
  endtask

  // One cycle: drive at negedge, advance the model, then check at the next negedge.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] thr,
                     input logic ar, input logic br);
    bit rdy;
    in_valid = v; in_data = d; threshold = thr; a_ready = ar; b_ready = br;
    rdy = (qa.size() < DEPTH) && (qb.size() < DEPTH);
    if (ar && qa.size() != 0) void'(qa.pop_front());
    if (br && qb.size() != 0) void'(qb.pop_front());
    if (v && rdy) begin
      if (d > thr) begin qa.push_back(d); ca++; end
      else         begin qb.push_back(d); cb++; end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH; i++) cyc(1'b0, 8'h00, 8'h80, 1'b1, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Mid-stream reset with three bytes held in lane A.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hA0 + 8'(i), 8'h10, 1'b0, 1'b1);
    chk("pre_rst_a_level", 32'(a_level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_level", 32'(a_level), 32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    model_clear();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Routing and tie: ties go to B; one-cycle latency checked via the model each cycle.
    cyc(1'b1, 8'h81, 8'h80, 1'b1, 1'b1);
    cyc(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 8'h80, 1'b1, 1'b1);
    cyc(1'b1, 8'hFF, 8'h80, 1'b1, 1'b1);
    chk("route_a_count", 32'(a_count), 32'd2);
    chk("route_b_count", 32'(b_count), 32'd2);
    drain();

    // Full stall on lane A; 0x14 waits until a slot frees.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i), 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h14, 8'h00, 1'b0, 1'b1);
    chk("stall_a_level", 32'(a_level), 32'd4);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head", 32'(a_data), 32'h10);
    cyc(1'b1, 8'h14, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h14, 8'h00, 1'b0, 1'b1);
    chk("stall_accepted_level", 32'(a_level), 32'd4);
    drain();

    // Concurrent push/pop on A at level 2; pointers wrap while level holds.
    cyc(1'b1, 8'h90, 8'h10, 1'b0, 1'b1);
    cyc(1'b1, 8'h91, 8'h10, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'h92 + 8'(i), 8'h10, 1'b1, 1'b1);
      chk("pp_a_level", 32'(a_level), 32'd2);
    end
    drain();

    // B back-pressured while A keeps flowing.
    cyc(1'b1, 8'h05, 8'h40, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h50 + 8'(i), 8'h40, 1'b1, 1'b0);
      chk("bp_b_data", 32'(b_data), 32'h05);
    end
    drain();

    // Counter wrap: 17 dispatches to B on a 4-bit counter.
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 8'hFF, 1'b1, 1'b1);
    chk("wrap_b_count", 32'(b_count), 32'd1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom_range(0, 7) == 0 ? $urandom : 32'h80),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
